// File: rtl/lsu_mem_sequencer.sv
// rtl/lsu_mem_sequencer.sv - load/store sequencer for a doubleword-wide data memory
// Loads issue one read; sub-word stores read-modify-write; SD writes directly.
module lsu_mem_sequencer #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_type,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [3:0] OP_SW  = 4'd0;
  localparam logic [3:0] OP_SH  = 4'd1;
  localparam logic [3:0] OP_SB  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LH  = 4'd4;
  localparam logic [3:0] OP_LB  = 4'd5;
  localparam logic [3:0] OP_LBU = 4'd6;
  localparam logic [3:0] OP_LHU = 4'd7;
  localparam logic [3:0] OP_LWU = 4'd8;
  localparam logic [3:0] OP_LD  = 4'd9;
  localparam logic [3:0] OP_SD  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        type_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  function automatic logic is_load(input logic [3:0] t);
    return (t >= OP_LW) && (t <= OP_LD);
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] size_log2(input logic [3:0] t);
    logic [1:0] s;
    case (t)
      OP_SB, OP_LB, OP_LBU: s = 2'd0;
      OP_SH, OP_LH, OP_LHU: s = 2'd1;
      OP_SW, OP_LW, OP_LWU: s = 2'd2;
      default:              s = 2'd3;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(input logic [3:0] t, input logic [2:0] a);
    logic m;
    case (size_log2(t))
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      default: m = |a[2:0];
    endcase
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] merge_lane(
    input logic [3:0]        t,
    input logic [2:0]        a,
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] src
  );
    logic [DATA_W-1:0] mask;
    logic [5:0]        off;
    off = {a, 3'b000};
    case (t)
      OP_SB:   mask = 64'h0000_0000_0000_00FF;
      OP_SH:   mask = 64'h0000_0000_0000_FFFF;
      OP_SW:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
    return (old & ~(mask << off)) | ((src & mask) << off);
  endfunction

  function automatic logic [DATA_W-1:0] extend_lane(
    input logic [3:0]        t,
    input logic [2:0]        a,
    input logic [DATA_W-1:0] rdata
  );
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] res;
    lane = rdata >> {a, 3'b000};
    case (t)
      OP_LB:   res = {{56{lane[7]}}, lane[7:0]};
      OP_LBU:  res = {56'b0, lane[7:0]};
      OP_LH:   res = {{48{lane[15]}}, lane[15:0]};
      OP_LHU:  res = {48'b0, lane[15:0]};
      OP_LW:   res = {{32{lane[31]}}, lane[31:0]};
      OP_LWU:  res = {32'b0, lane[31:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      type_r    <= 4'd0;
      addr_r    <= '0;
      wdata_r   <= '0;
      load_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && op_valid) begin
        type_r  <= op_type;
        addr_r  <= op_addr;
        wdata_r <= op_wdata;
      end
      // wdata_r holds the store source until the read returns, then the merged doubleword
      if (state == S_READ && mem_ack) begin
        if (is_load(type_r)) begin
          load_data <= extend_lane(type_r, addr_r[2:0], mem_rdata);
        end else begin
          wdata_r <= merge_lane(type_r, addr_r[2:0], mem_rdata, wdata_r);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (op_type > OP_SD || misaligned(op_type, op_addr[2:0])) begin
            state_nxt = S_ERR;
          end else if (op_type == OP_SD) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = is_load(type_r) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr  = {addr_r[ADDR_W-1:3], 3'b000};
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb/tb_lsu_mem_sequencer.sv - directed bench with a byte-level memory model
module tb_lsu_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_type;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic        done;
  logic        err;
  logic [63:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  lsu_mem_sequencer #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata),
    .done(done), .err(err), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] dmem [logic [63:0]];

  bit          chk_en = 0;
  logic        e_ready, e_req, e_we, e_done, e_err;
  logic [63:0] e_addr, e_wdata, e_load;
  logic [63:0] seen_wdata;
  int          done_idx;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [3:0] t);
    case (t)
      4'd2, 4'd5, 4'd6: return 1;
      4'd1, 4'd4, 4'd7: return 2;
      4'd0, 4'd3, 4'd8: return 4;
      default:          return 8;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [3:0] t, input logic [63:0] a,
                                             input logic [63:0] dw);
    int n = size_of(t);
    int off = int'(a[2:0]);
    logic [63:0] v = 64'h0;
    bit sgn = (t == 4'd3 || t == 4'd4 || t == 4'd5);
    for (int i = 0; i < n; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
    if (sgn && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] model_merge(input logic [3:0] t, input logic [63:0] a,
                                              input logic [63:0] dw, input logic [63:0] src);
    int n = size_of(t);
    int off = int'(a[2:0]);
    logic [63:0] v = dw;
    for (int i = 0; i < n && off + i < 8; i++) v[8*(off+i) +: 8] = src[8*i +: 8];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      chk("op_ready", {63'b0, op_ready}, {63'b0, e_ready});
      chk("mem_req", {63'b0, mem_req}, {63'b0, e_req});
      chk("done", {63'b0, done}, {63'b0, e_done});
      if (e_req) begin
        chk("mem_we", {63'b0, mem_we}, {63'b0, e_we});
        chk("mem_addr", mem_addr, e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_done) chk("err", {63'b0, err}, {63'b0, e_err});
      chk("load_data", load_data, e_load);
      if (mem_req && mem_we) seen_wdata = mem_wdata;
    end
  end

  // Phase codes per cycle after accept: 1 read, 2 write, 3 done, 4 error-done
  task automatic do_op(input logic [3:0] t, input logic [63:0] a, input logic [63:0] wd,
                       input int d, input int rst_at);
    int n;
    bit isld, bad, aborted;
    logic [63:0] old, nw;
    int ph[$];
    n = size_of(t);
    bad = (t > 4'd10) || ((a % n) != 0);
    isld = (t >= 4'd3 && t <= 4'd9);
    old = dmem.exists(a >> 3) ? dmem[a >> 3] : 64'h0;
    nw = (t == 4'd10) ? wd : model_merge(t, a, old, wd);
    if (bad) ph.push_back(4);
    else begin
      if (t != 4'd10) repeat (d + 1) ph.push_back(1);
      if (!isld) repeat (d + 1) ph.push_back(2);
      ph.push_back(3);
    end
    done_idx = 0;
    aborted = 0;
    @(negedge clk);
    op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = wd; mem_ack = 1'b0;
    e_ready = 1; e_req = 0; e_we = 0; e_done = 0; e_err = 0;
    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      op_valid = 1'b0; mem_ack = 1'b0; reset = 1'b0;
      if (aborted) begin
        e_ready = 1; e_req = 0; e_we = 0; e_done = 0; e_err = 0; e_load = 64'h0;
        break;
      end
      e_ready = 0;
      e_req = (ph[k] == 1 || ph[k] == 2);
      e_we = (ph[k] == 2);
      e_addr = {a[63:3], 3'b000};
      e_wdata = nw;
      e_done = (ph[k] >= 3);
      e_err = (ph[k] == 4);
      if (ph[k] == 3 && isld) e_load = model_load(t, a, old);
      mem_rdata = old;
      if (k + 2 == rst_at) begin
        reset = 1'b1;
        aborted = 1;
      end else begin
        mem_ack = e_req && (k + 1 == ph.size() || ph[k+1] != ph[k]);
      end
      #3;
      if (done) done_idx = k + 2;
    end
    if (!bad && !aborted && !isld) dmem[a >> 3] = nw;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_type = 4'd0; op_addr = 64'h0; op_wdata = 64'h0;
    mem_rdata = 64'h0; mem_ack = 1'b0; e_load = 64'h0; seen_wdata = 64'h0; done_idx = 0;
    dmem[64'h1000 >> 3] = 64'h1122_3344_8566_7788;
    dmem[64'h2000 >> 3] = 64'h8000_0001_DEAD_BEEF;
    dmem[64'h3000 >> 3] = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clk);
    #2;
    chk("rst op_ready", {63'b0, op_ready}, 64'h1);
    chk("rst done", {63'b0, done}, 64'h0);
    chk("rst err", {63'b0, err}, 64'h0);
    chk("rst load_data", load_data, 64'h0);
    chk("rst mem_req", {63'b0, mem_req}, 64'h0);
    chk("rst mem_we", {63'b0, mem_we}, 64'h0);
    chk("rst mem_addr", mem_addr, 64'h0);
    chk("rst mem_wdata", mem_wdata, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    e_ready = 1; e_req = 0; e_we = 0; e_done = 0; e_err = 0;
    chk_en = 1;

    do_op(4'd5, 64'h1003, 64'h0, 0, 0);
    chk("LB value", load_data, 64'hFFFF_FFFF_FFFF_FF85);
    chk("LB latency", 64'(done_idx), 64'd3);
    do_op(4'd6, 64'h1003, 64'h0, 0, 0);
    chk("LBU value", load_data, 64'h0000_0000_0000_0085);
    do_op(4'd8, 64'h2004, 64'h0, 0, 0);
    chk("LWU value", load_data, 64'h0000_0000_8000_0001);
    do_op(4'd3, 64'h2004, 64'h0, 1, 0);
    chk("LW value", load_data, 64'hFFFF_FFFF_8000_0001);

    do_op(4'd1, 64'h3002, 64'hAAAA_BBBB_CCCC_1234, 0, 0);
    chk("SH write", seen_wdata, 64'hFFFF_FFFF_1234_FFFF);
    chk("SH latency", 64'(done_idx), 64'd4);
    do_op(4'd10, 64'h4000, 64'h0123_4567_89AB_CDEF, 0, 0);
    chk("SD write", seen_wdata, 64'h0123_4567_89AB_CDEF);
    chk("SD latency", 64'(done_idx), 64'd3);

    do_op(4'd4, 64'h5001, 64'h0, 0, 0);
    chk("LH misaligned latency", 64'(done_idx), 64'd2);
    chk("LH misaligned load_data held", load_data, 64'hFFFF_FFFF_8000_0001);
    do_op(4'd12, 64'h5000, 64'h0, 0, 0);
    chk("illegal latency", 64'(done_idx), 64'd2);
    do_op(4'd9, 64'h4001, 64'h0, 0, 0);
    chk("LD misaligned latency", 64'(done_idx), 64'd2);

    do_op(4'd9, 64'h4000, 64'h0, 0, 0);
    chk("LD value", load_data, 64'h0123_4567_89AB_CDEF);
    do_op(4'd7, 64'h3002, 64'h0, 0, 0);
    chk("LHU value", load_data, 64'h0000_0000_0000_1234);
    do_op(4'd2, 64'h3007, 64'h0000_0000_0000_005A, 2, 0);
    chk("SB write", seen_wdata, 64'h5AFF_FFFF_1234_FFFF);
    do_op(4'd9, 64'h3000, 64'h0, 0, 0);
    chk("LD after SB", load_data, 64'h5AFF_FFFF_1234_FFFF);
    do_op(4'd0, 64'h3004, 64'h0000_0000_8765_4321, 0, 0);
    do_op(4'd8, 64'h3004, 64'h0, 3, 0);
    chk("LWU after SW", load_data, 64'h0000_0000_8765_4321);

    do_op(4'd0, 64'h6004, 64'h0000_0000_CAFE_F00D, 5, 9);
    #3;
    chk("abort op_ready", {63'b0, op_ready}, 64'h1);
    chk("abort no done", 64'(done_idx), 64'd0);
    chk("abort mem_req", {63'b0, mem_req}, 64'h0);

    @(negedge clk);
    e_ready = 1; e_req = 0; e_done = 0;
    @(negedge clk);
    #4;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Sequential load/store unit between the multicycle datapath and the doubleword-wide data memory.
- Loads: issues one memory read, extracts the addressed byte, half or word lane, and sign- or zero-extends it to 64 bits.
- Sub-word stores: performs read-modify-write (read doubleword, merge lane, write back). Full-doubleword stores write directly.
- Uses the same 4-bit access-type encoding as the datapath's store-merge/load-extend logic. Owns all memory handshaking.

Parameters:
- ADDR_W, 64, byte-address width.
- DATA_W, 64, memory word width; fixed at 64, lane logic assumes 8 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request strobe; sampled only in IDLE.
- op_ready  out  1  high only in IDLE.
- op_type  in  4  0 SW, 1 SH, 2 SB, 3 LW, 4 LH, 5 LB, 6 LBU, 7 LHU, 8 LWU, 9 LD, 10 SD; 11-15 illegal.
- op_addr  in  ADDR_W  byte address.
- op_wdata  in  64  store source (rs2); lane data taken from the low bits.
- done  out  1  one-cycle pulse at completion.
- err  out  1  valid with done: misaligned address or illegal op_type.
- load_data  out  64  extended load result; held until the next done.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  doubleword-aligned address {op_addr[ADDR_W-1:3], 3'b0}.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data; valid in the mem_ack cycle.
- mem_ack  in  1  completes the current request; may arrive any cycle ≥1 after mem_req rises.

Behaviour:
- Reset values: op_ready=1, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. State=IDLE.
- Reset mid-transaction: returns to IDLE next cycle, drops mem_req, and emits no done.
- IDLE:
  - On op_valid, latch op_type, op_addr and op_wdata.
  - Illegal type, or misaligned access (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0) → ERR.
  - SD → WRITE.
  - All other legal types → READ.
- READ:
  - Drives mem_req=1, mem_we=0.
  - On mem_ack: loads → compute load_data → DONE. Sub-word stores → register the merged word → WRITE.
- WRITE:
  - Drives mem_req=1, mem_we=1, mem_wdata = merged word (SD: op_wdata).
  - On mem_ack → DONE.
- DONE: done=1, err=0 → IDLE.
- ERR: done=1, err=1, no memory access, load_data unchanged → IDLE.
- Lane offset: off = op_addr[2:0]*8.
- Merge rule: replace bytes [off +: n] of the read doubleword with op_wdata[n-1:0], where n = 8/16/32 for SB/SH/SW. All other bytes are preserved.
- Extend rules:
  - LB/LH/LW: sign-extend from the lane MSB.
  - LBU/LHU/LWU: zero-extend. LWU zero-extends all 32 bits.
  - LD: full doubleword.
- Latency with ack one cycle after req: load = 3 cycles from accept to done; sub-word store = 4; SD = 3; error = 2.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1. mem_req deasserts the cycle after ack.
- op_valid outside IDLE is ignored; no queuing.

Test Plan:
- Reset, then LB @0x1003, memory dword 0x1122_3344_8566_7788 → load_data 0xFFFF_FFFF_FFFF_FF85? No: byte 3 = 0x85 → 0xFFFF_FFFF_FFFF_FF85; LBU same → 0x0000_0000_0000_0085.
- LWU @0x2004, dword 0x8000_0001_DEAD_BEEF → 0x0000_0000_8000_0001; LW same → 0xFFFF_FFFF_8000_0001.
- SH @0x3002, op_wdata 0xAAAA_BBBB_CCCC_1234, memory 0xFFFF_FFFF_FFFF_FFFF → one read then one write of 0xFFFF_FFFF_1234_FFFF; done at cycle 4.
- SD @0x4000, data 0x0123_4567_89AB_CDEF → single write, no read cycle; done at cycle 3.
- LH @0x5001 → done with err=1, mem_req never asserted, load_data unchanged. op_type 12 → same.
- SW with mem_ack delayed 5 cycles, reset asserted in WRITE → mem_req low next cycle, no done, op_ready=1.
